// File: rtl/regfile_scoreboard.sv
// Parametrised register file with write-to-read bypass and a per-register busy scoreboard.
// Decode reserves destinations through issue; writeback clears them.
module regfile_scoreboard #(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned NREGS  = 32,
    parameter  int unsigned NRD    = 2,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [NREGS-1:0][XLEN-1:0]      initial_values_i,
    input  logic [NRD-1:0][AW-1:0]          rd_addr_i,
    output logic [NRD-1:0][XLEN-1:0]        rd_data_o,
    output logic [NRD-1:0]                  rd_busy_o,
    input  logic                            wr_en_i,
    input  logic [AW-1:0]                   wr_addr_i,
    input  logic [XLEN-1:0]                 wr_data_i,
    input  logic                            issue_en_i,
    input  logic [AW-1:0]                   issue_addr_i,
    output logic                            issue_ok_o,
    output logic [NREGS-1:0]                busy_vec_o,
    output logic [NREGS-1:0][XLEN-1:0]      register_check_o
);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;
    logic                       wr_hit, issue_hit;

    // Addresses at or above NREGS only exist when NREGS is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return 32'(addr) < NREGS;
    endfunction

    assign wr_hit    = wr_en_i && (wr_addr_i != '0) && in_range(wr_addr_i);
    // WAW check looks at registered busy only; a same-cycle clear does not help.
    assign issue_ok_o = (issue_addr_i == '0) || !in_range(issue_addr_i) || !busy_q[issue_addr_i];
    assign issue_hit = issue_en_i && issue_ok_o && (issue_addr_i != '0) && in_range(issue_addr_i);

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_hit) begin
            regs_d[wr_addr_i] = wr_data_i;
            busy_d[wr_addr_i] = 1'b0;
        end
        // Set after clear so a same-cycle reservation wins.
        if (issue_hit) begin
            busy_d[issue_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            regs_q    <= initial_values_i;
            regs_q[0] <= '0;
            busy_q    <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NRD; p++) begin
            rd_data_o[p] = '0;
            rd_busy_o[p] = 1'b0;
            if ((rd_addr_i[p] != '0) && in_range(rd_addr_i[p])) begin
                if ((BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i[p])) begin
                    rd_data_o[p] = wr_data_i;
                end else begin
                    rd_data_o[p] = regs_q[rd_addr_i[p]];
                    rd_busy_o[p] = busy_q[rd_addr_i[p]];
                end
            end
        end
    end

    assign busy_vec_o       = busy_q;
    assign register_check_o = regs_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a bypassing 32-register instance and a non-bypassing
// 24-register instance share stimulus and are compared against an array-based model.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NA   = 32;
    localparam int NB   = 24;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       reset;
    logic [NA-1:0][XLEN-1:0]    init_a;
    logic [NB-1:0][XLEN-1:0]    init_b;
    logic [NRD-1:0][AW-1:0]     rd_addr;
    logic                       wr_en;
    logic [AW-1:0]              wr_addr;
    logic [XLEN-1:0]            wr_data;
    logic                       issue_en;
    logic [AW-1:0]              issue_addr;

    logic [NRD-1:0][XLEN-1:0]   rd_data_a, rd_data_b;
    logic [NRD-1:0]             rd_busy_a, rd_busy_b;
    logic                       issue_ok_a, issue_ok_b;
    logic [NA-1:0]              busy_vec_a;
    logic [NB-1:0]              busy_vec_b;
    logic [NA-1:0][XLEN-1:0]    rc_a;
    logic [NB-1:0][XLEN-1:0]    rc_b;

    assign init_b = init_a[NB-1:0];

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NA), .NRD(NRD), .BYPASS(1)) dut_a (
        .clk_i(clk), .reset_i(reset), .initial_values_i(init_a),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .issue_ok_o(issue_ok_a),
        .busy_vec_o(busy_vec_a), .register_check_o(rc_a)
    );

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NB), .NRD(NRD), .BYPASS(0)) dut_b (
        .clk_i(clk), .reset_i(reset), .initial_values_i(init_b),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .issue_ok_o(issue_ok_b),
        .busy_vec_o(busy_vec_b), .register_check_o(rc_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: index 0 = bypassing 32-reg instance, 1 = non-bypassing 24-reg one.
    logic [31:0] m_mem  [2][32];
    bit          m_busy [2][32];

    function automatic int nregs(input int k);
        return (k == 0) ? NA : NB;
    endfunction

    function automatic bit valid_addr(input int k, input logic [AW-1:0] a);
        return (a != 0) && (int'(a) < nregs(k));
    endfunction

    function automatic logic [31:0] exp_data(input int k, input logic [AW-1:0] a);
        if (!valid_addr(k, a)) return 32'd0;
        if (k == 0 && wr_en && wr_addr == a) return wr_data;
        return m_mem[k][a];
    endfunction

    function automatic logic exp_busy(input int k, input logic [AW-1:0] a);
        if (!valid_addr(k, a)) return 1'b0;
        if (k == 0 && wr_en && wr_addr == a) return 1'b0;
        return m_busy[k][a];
    endfunction

    function automatic logic exp_ok(input int k);
        if (!valid_addr(k, issue_addr)) return 1'b1;
        return !m_busy[k][issue_addr];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        logic [31:0] ev, ov;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < NRD; p++) begin
                chk($sformatf("rd_data%0d[%0d]", k, p),
                    (k == 0) ? rd_data_a[p] : rd_data_b[p], exp_data(k, rd_addr[p]));
                chk($sformatf("rd_busy%0d[%0d]", k, p),
                    32'((k == 0) ? rd_busy_a[p] : rd_busy_b[p]), 32'(exp_busy(k, rd_addr[p])));
            end
            chk($sformatf("issue_ok%0d", k), 32'((k == 0) ? issue_ok_a : issue_ok_b),
                32'(exp_ok(k)));
            ev = '0;
            for (int i = 0; i < nregs(k); i++) ev[i] = m_busy[k][i];
            ov = (k == 0) ? busy_vec_a : 32'(busy_vec_b);
            chk($sformatf("busy_vec%0d", k), ov, ev);
            for (int i = 0; i < nregs(k); i++) begin
                chk($sformatf("register_check%0d[%0d]", k, i),
                    (k == 0) ? rc_a[i] : rc_b[i], m_mem[k][i]);
            end
        end
    endtask

    task automatic model_edge();
        bit ok;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[k][i]  = (i == 0) ? 32'd0 : init_a[i];
                    m_busy[k][i] = 1'b0;
                end
            end else begin
                ok = exp_ok(k);
                if (wr_en && valid_addr(k, wr_addr)) begin
                    m_mem[k][wr_addr]  = wr_data;
                    m_busy[k][wr_addr] = 1'b0;
                end
                if (issue_en && ok && valid_addr(k, issue_addr)) m_busy[k][issue_addr] = 1'b1;
            end
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic step();
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset    = 1'b0;
        wr_en    = 1'b0;
        issue_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NA; i++) init_a[i] = 32'(3000 + i);
        rd_addr[0] = 5'd1;
        rd_addr[1] = 5'd2;
        wr_addr    = '0;
        wr_data    = '0;
        issue_addr = 5'd5;
        idle();
        reset = 1'b1;
        model_edge();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and preload
        settle();
        chk("t1_rd0", rd_data_a[0], 32'd3001);
        chk("t1_rd1", rd_data_a[1], 32'd3002);
        chk("t1_rc0", rc_a[0], 32'd0);
        chk("t1_busy", busy_vec_a, 32'd0);
        chk("t1_ok", 32'(issue_ok_a), 32'd1);
        step();

        // RAW hazard, then bypassed writeback
        issue_en = 1'b1; issue_addr = 5'd7;
        settle(); step();
        idle(); rd_addr[0] = 5'd7;
        settle();
        chk("t2_rdbusy", 32'(rd_busy_a[0]), 32'd1);
        chk("t2_ok", 32'(issue_ok_a), 32'd0);
        step();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd6011;
        settle();
        chk("t2_byp", rd_data_a[0], 32'd6011);
        chk("t2_bypbusy", 32'(rd_busy_a[0]), 32'd0);
        chk("t2_ok_reg", 32'(issue_ok_a), 32'd0);
        step();
        idle(); settle();
        chk("t2_busy7", 32'(busy_vec_a[7]), 32'd0);
        chk("t2_rc7", rc_a[7], 32'd6011);
        step();

        // Same-cycle issue and write: set wins
        issue_en = 1'b1; issue_addr = 5'd10; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'd1;
        settle(); step();
        idle(); issue_en = 1'b1; issue_addr = 5'd10;
        settle();
        chk("t3_rc10", rc_a[10], 32'd1);
        chk("t3_busy10", 32'(busy_vec_a[10]), 32'd1);
        chk("t3_ok", 32'(issue_ok_a), 32'd0);
        step();
        idle(); settle();
        chk("t3_busy10b", 32'(busy_vec_a[10]), 32'd1);
        step();

        // Register 0
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hdeadbeef;
        issue_en = 1'b1; issue_addr = 5'd0; rd_addr[1] = 5'd0;
        settle();
        chk("t4_ok", 32'(issue_ok_a), 32'd1);
        chk("t4_rd", rd_data_a[1], 32'd0);
        step();
        idle(); settle();
        chk("t4_rc0", rc_a[0], 32'd0);
        chk("t4_busy0", 32'(busy_vec_a[0]), 32'd0);
        step();

        // Reset discards reservations and same-cycle write
        issue_en = 1'b1; issue_addr = 5'd3; settle(); step();
        issue_addr = 5'd4; settle(); step();
        idle(); reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd5;
        settle(); step();
        idle(); settle();
        chk("t5_busy_a", busy_vec_a, 32'd0);
        chk("t5_busy_b", 32'(busy_vec_b), 32'd0);
        chk("t5_rc3", rc_a[3], 32'd3003);
        step();

        // No bypass on instance b
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55; rd_addr[0] = 5'd5;
        settle();
        chk("t6_nobyp", rd_data_b[0], 32'd3005);
        chk("t6_byp", rd_data_a[0], 32'h55);
        step();
        idle(); settle();
        chk("t6_after", rd_data_b[0], 32'h55);
        step();

        // Out-of-range addresses on the 24-register instance
        issue_en = 1'b1; issue_addr = 5'd25; wr_en = 1'b1; wr_addr = 5'd25;
        wr_data = 32'h1234; rd_addr[1] = 5'd25;
        settle();
        chk("oor_ok", 32'(issue_ok_b), 32'd1);
        chk("oor_rd", rd_data_b[1], 32'd0);
        step();

        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 63) == 0);
            wr_en      = $urandom_range(0, 1) == 1;
            wr_addr    = 5'($urandom_range(0, 31));
            wr_data    = $urandom;
            issue_en   = $urandom_range(0, 2) != 0;
            issue_addr = 5'($urandom_range(0, 31));
            rd_addr[0] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr[1] = ($urandom_range(0, 3) == 0) ? issue_addr : 5'($urandom_range(0, 31));
            settle();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-cycle register file, aimed at the upcoming pipelined RV32I core.
- Generalised in data width, register count and number of read ports.
- Adds write-to-read bypass and a per-register pending ("busy") scoreboard that lets decode detect RAW and WAW hazards.
- Sits between decode (issue/read) and writeback (write); keeps the preload-on-reset and register_check debug conventions.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; register 0 hardwired to zero
AW, $clog2(NREGS), register address width (derived, not overridden)
NRD, 2, number of combinational read ports
BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = no forwarding

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
initial_values  input  NREGS x XLEN  values loaded into registers on reset
rd_addr  input  NRD x AW  read port addresses
rd_data  output  NRD x XLEN  read data, combinational
rd_busy  output  NRD  read operand still pending (RAW hazard)
wr_en  input  1  writeback valid
wr_addr  input  AW  writeback destination
wr_data  input  XLEN  writeback data
issue_en  input  1  decode requests reservation of a destination
issue_addr  input  AW  destination to reserve
issue_ok  output  1  reservation would be accepted this cycle
busy_vec  output  NREGS  current pending bit per register
register_check  output  NREGS x XLEN  debug view of register contents (registered state)

Behaviour:
- Reset (sync, active-high, highest priority):
  - At the rising edge with reset=1: reg[i] <= initial_values[i] for i>=1; reg[0] <= 0; busy_vec <= 0.
  - Any wr_en or issue_en in the same cycle is ignored.
  - Reset asserted mid-operation discards all pending reservations.
- Register 0:
  - Always reads 0; never busy.
  - Writes to it are dropped; issue to it is accepted (issue_ok=1) but sets no bit.
- Write (rising edge, wr_en=1, wr_addr!=0, wr_addr<NREGS): reg[wr_addr] <= wr_data; busy[wr_addr] <= 0.
  - A write to a non-busy register is legal and updates data.
- Issue:
  - issue_ok = (issue_addr==0) || !busy[issue_addr].
  - A write that clears the same register in the same cycle does not make issue_ok true; the WAW check uses registered busy only.
  - At the rising edge with issue_en && issue_ok && issue_addr!=0: busy[issue_addr] <= 1.
  - issue_en with issue_ok=0 is ignored; no state change.
- Simultaneous write and issue to the same register (issue_ok=1 requires it to be non-busy): data written and busy ends at 1. Set wins over clear.
- Read, port i, combinational, zero latency:
  - rd_addr==0 or rd_addr>=NREGS: rd_data=0, rd_busy=0.
  - Else if BYPASS && wr_en && wr_addr==rd_addr: rd_data=wr_data, rd_busy=0.
  - Else: rd_data=reg[rd_addr], rd_busy=busy[rd_addr].
  - With BYPASS=0, the written value becomes visible the cycle after the edge.
- Out-of-range addresses (NREGS not a power of two): writes and issues dropped, issue_ok=1, reads as above.
- Latency:
  - Write to register_check/busy_vec: 1 edge.
  - Write to read with bypass: 0 cycles.
- All outputs after reset:
  - register_check = initial_values with entry 0 = 0; busy_vec=0.
  - rd_busy=0 and issue_ok=1 for all addresses.
  - rd_data = preloaded values.

Test Plan:
1. Reset with initial_values[i]=3000+i, rd_addr={1,2} -> rd_data={3001,3002}, register_check[0]=0, busy_vec=0, issue_ok=1.
2. issue x7 at edge, then rd_addr[0]=7 -> rd_busy[0]=1, issue_ok=0 for issue_addr=7; wr_en x7=6011 held combinationally -> rd_data[0]=6011, rd_busy[0]=0 (BYPASS=1); after edge busy_vec[7]=0, register_check[7]=6011.
3. Same-cycle issue x10 and write x10=1 (x10 not busy) -> after edge register_check[10]=1, busy_vec[10]=1; following issue x10 -> issue_ok=0, busy unchanged.
4. Write x0=0xdeadbeef, issue x0 -> register_check[0]=0, busy_vec[0]=0, rd_data for addr 0 = 0, issue_ok=1.
5. Issue x3, x4 on consecutive edges, then reset=1 with wr_en x3=5 -> after edge busy_vec=0, register_check[3]=3003 (write ignored).
6. BYPASS=0 instance: write x5=0x55 -> same cycle rd_data(x5)=3005; after edge rd_data(x5)=0x55.
